axi_stream_hdr_arbiter: RTL and testbench
=========================================

// Module: axi_stream_hdr_arbiter
// PURPOSE
//  Packet-atomic round-robin arbiter that shares one header-insert engine between NUM_SRC sources.
//  Each source offers a header descriptor and a payload stream.
//  Per granted packet, the block forwards exactly one header on the insert channel, then the payload
//  beats up to and including las_in, then releases the grant.
//  Sits directly upstream of the insert engine; both share clk/rst_n.
// PARAMETERS
//  NUM_SRC       4               number of requesting sources (2..8)
//  DATA_WD       32              payload/header data width, bits
//  DATA_BYTE_WD  DATA_WD/8       keep width
//  BYTE_CNT_WD   $clog2(DATA_BYTE_WD)  header byte-count width is BYTE_CNT_WD+1
//  SRC_WD        $clog2(NUM_SRC) grant index width
// PORTS
//  clk              in   1                        clock, all logic rising-edge
//  rst_n            in   1                        synchronous active-low reset
//  s_valid_in       in   NUM_SRC                  per-source payload valid
//  s_data_in        in   NUM_SRC*DATA_WD          payload data, source i at [i*DATA_WD +: DATA_WD]
//  s_keep_in        in   NUM_SRC*DATA_BYTE_WD     payload keep, same packing
//  s_las_in         in   NUM_SRC                  payload last beat
//  s_ready_in       out  NUM_SRC                  payload ready, one-hot or zero
//  s_valid_hdr      in   NUM_SRC                  header descriptor valid
//  s_data_hdr       in   NUM_SRC*DATA_WD          header data
//  s_keep_hdr       in   NUM_SRC*DATA_BYTE_WD     header keep
//  s_byte_hdr_cnt   in   NUM_SRC*(BYTE_CNT_WD+1)  header byte count
//  s_ready_hdr      out  NUM_SRC                  header ready, one-hot or zero
//  valid_in/data_in/keep_in/las_in  out  1/DATA_WD/DATA_BYTE_WD/1  payload to insert engine
//  ready_in         in   1                        insert engine payload ready
//  valid_insert/data_insert/keep_insert/byte_insert_cnt  out  1/DATA_WD/DATA_BYTE_WD/BYTE_CNT_WD+1  header to engine
//  ready_insert     in   1                        insert engine header ready
//  grant_id         out  SRC_WD                   currently/last granted source
//  busy             out  1                        high in HDR or PAYLOAD
// BEHAVIOUR
//  Reset (rst_n=0 at clk edge):
//   - state=IDLE, rr_ptr=0, grant_id=0, busy=0.
//   - All valid and ready outputs are 0; data/keep/cnt outputs are 0.
//   - A mid-packet reset abandons the packet with no flush. The engine is reset by the same rst_n.
//  States:
//   - IDLE:
//     - A source i is eligible when s_valid_in[i] & s_valid_hdr[i].
//     - Search from rr_ptr upward with wrap and pick the first eligible source.
//     - Register grant_id=i and go to HDR on the next edge (1-cycle arbitration latency).
//     - No eligible source: stay in IDLE.
//     - All handshake outputs are 0 in IDLE.
//   - HDR:
//     - valid_insert = s_valid_hdr[g]; data/keep/byte cnt are muxed from g.
//     - s_ready_hdr[g] = ready_insert; all other s_ready_hdr bits are 0.
//     - Combinational pass-through, 0 latency.
//     - valid_insert & ready_insert -> PAYLOAD.
//   - PAYLOAD:
//     - valid_in/data_in/keep_in/las_in are muxed from g; s_ready_in[g] = ready_in.
//     - valid_in & ready_in & las_in -> IDLE, rr_ptr = g+1 mod NUM_SRC.
//  Handshake rules:
//   - Valid and data stay muxed from g, so source stability is passed through unchanged.
//   - The block never drops or duplicates a beat.
//   - Sources that are not granted see ready=0 whatever their valid is.
//   - Eligibility is sampled only in IDLE. If a source deasserts valid after grant, the block waits in its state.
//   - A single-beat packet (las on the first beat) is legal: HDR -> PAYLOAD -> IDLE.
//  Fairness:
//   - The just-served source has lowest priority next round.
//   - With all sources eligible, the grant order is 0,1,2,3,0...
//  Widths:
//   - byte_insert_cnt is passed through unchecked; its range is the engine's concern.
//   - rr_ptr wraps NUM_SRC-1 -> 0; non-power-of-2 NUM_SRC wraps explicitly.
//  Simultaneous events:
//   - A source raising valid in the same cycle IDLE evaluates is eligible.
//   - Packet-last handshake and new requests in the same cycle: the new grant is decided next cycle in IDLE.
//   - Minimum gap between packets is 1 cycle.
// TESTING (NUM_SRC=4, DATA_WD=32)
//  1. Only src2 requests, hdr 0xA5A5A5A5 cnt=3, 2-beat payload.
//     -> grant_id=2; valid_insert 1 cycle after request; then 2 beats; las on beat 2; back in IDLE; rr_ptr=3.
//  2. All 4 sources continuously eligible, 1-beat packets.
//     -> grant sequence 0,1,2,3,0; each packet costs 3 cycles with ready always 1.
//  3. Grant src1, ready_in toggling 1010 over a 4-beat packet.
//     -> exactly 4 beats delivered in order; s_ready_in=0010b only while granted; no other source acked.
//  4. src0 has payload valid but no header valid; src3 has both.
//     -> src3 granted; src0 is never granted until s_valid_hdr[0]=1.
//  5. rst_n=0 for 1 cycle mid-payload of src2.
//     -> next cycle all outputs 0, busy=0; rr_ptr=0 so src0 wins next if eligible.
//  6. ready_insert held 0 for 5 cycles in HDR.
//     -> valid_insert and header data held stable; s_ready_hdr=0; no payload ready until the header is accepted.

Source files
------------

// File: rtl/axi_stream_hdr_arbiter_if.sv
// Bundle of the per-source header/payload channels and the shared insert-engine channels.
// master = the arbiter; slave = the environment (sources plus insert engine).
interface axi_stream_hdr_arbiter_if #(
    parameter int NUM_SRC      = 4,
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD),
    parameter int SRC_WD       = $clog2(NUM_SRC)
);
    logic [NUM_SRC-1:0]                   s_valid_in;
    logic [NUM_SRC*DATA_WD-1:0]           s_data_in;
    logic [NUM_SRC*DATA_BYTE_WD-1:0]      s_keep_in;
    logic [NUM_SRC-1:0]                   s_las_in;
    logic [NUM_SRC-1:0]                   s_ready_in;
    logic [NUM_SRC-1:0]                   s_valid_hdr;
    logic [NUM_SRC*DATA_WD-1:0]           s_data_hdr;
    logic [NUM_SRC*DATA_BYTE_WD-1:0]      s_keep_hdr;
    logic [NUM_SRC*(BYTE_CNT_WD+1)-1:0]   s_byte_hdr_cnt;
    logic [NUM_SRC-1:0]                   s_ready_hdr;

    logic                                 valid_in;
    logic [DATA_WD-1:0]                   data_in;
    logic [DATA_BYTE_WD-1:0]              keep_in;
    logic                                 las_in;
    logic                                 ready_in;
    logic                                 valid_insert;
    logic [DATA_WD-1:0]                   data_insert;
    logic [DATA_BYTE_WD-1:0]              keep_insert;
    logic [BYTE_CNT_WD:0]                 byte_insert_cnt;
    logic                                 ready_insert;

    logic [SRC_WD-1:0]                    grant_id;
    logic                                 busy;

    modport master (
        input  s_valid_in, s_data_in, s_keep_in, s_las_in,
        input  s_valid_hdr, s_data_hdr, s_keep_hdr, s_byte_hdr_cnt,
        output s_ready_in, s_ready_hdr,
        output valid_in, data_in, keep_in, las_in,
        input  ready_in,
        output valid_insert, data_insert, keep_insert, byte_insert_cnt,
        input  ready_insert,
        output grant_id, busy
    );

    modport slave (
        output s_valid_in, s_data_in, s_keep_in, s_las_in,
        output s_valid_hdr, s_data_hdr, s_keep_hdr, s_byte_hdr_cnt,
        input  s_ready_in, s_ready_hdr,
        input  valid_in, data_in, keep_in, las_in,
        output ready_in,
        input  valid_insert, data_insert, keep_insert, byte_insert_cnt,
        output ready_insert,
        input  grant_id, busy
    );
endinterface

// File: rtl/axi_stream_hdr_arbiter.sv
// Packet-atomic round-robin arbiter: one header then the payload up to last for the granted
// source, with zero-latency pass-through of both channels to the shared insert engine.
module axi_stream_hdr_arbiter #(
    parameter int NUM_SRC      = 4,
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD),
    parameter int SRC_WD       = $clog2(NUM_SRC)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    axi_stream_hdr_arbiter_if.master bus
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HDR     = 2'd1,
        ST_PAYLOAD = 2'd2
    } state_t;

    state_t              state_reg;
    logic [SRC_WD-1:0]   grant_id_reg;
    logic [SRC_WD-1:0]   rr_ptr_reg;
    logic                busy_reg;

    logic [DATA_WD-1:0]      src_data_in  [NUM_SRC];
    logic [DATA_BYTE_WD-1:0] src_keep_in  [NUM_SRC];
    logic [DATA_WD-1:0]      src_data_hdr [NUM_SRC];
    logic [DATA_BYTE_WD-1:0] src_keep_hdr [NUM_SRC];
    logic [BYTE_CNT_WD:0]    src_cnt_hdr  [NUM_SRC];
    logic [SRC_WD-1:0]       cand_idx     [NUM_SRC];

    logic [NUM_SRC-1:0]  eligible;
    logic                pick_valid_next;
    logic [SRC_WD-1:0]   pick_idx_next;
    logic [SRC_WD-1:0]   rr_ptr_next;
    logic                g_valid_hdr;
    logic                g_valid_in;
    logic                g_las_in;

    assign eligible = bus.s_valid_in & bus.s_valid_hdr;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
            logic [SRC_WD:0] rot_sum;

            assign src_data_in[gi]  = bus.s_data_in[gi*DATA_WD +: DATA_WD];
            assign src_keep_in[gi]  = bus.s_keep_in[gi*DATA_BYTE_WD +: DATA_BYTE_WD];
            assign src_data_hdr[gi] = bus.s_data_hdr[gi*DATA_WD +: DATA_WD];
            assign src_keep_hdr[gi] = bus.s_keep_hdr[gi*DATA_BYTE_WD +: DATA_BYTE_WD];
            assign src_cnt_hdr[gi]  = bus.s_byte_hdr_cnt[gi*(BYTE_CNT_WD+1) +: (BYTE_CNT_WD+1)];

            // Rotated search order starting at rr_ptr; explicit wrap keeps non-power-of-2 counts correct.
            assign rot_sum      = {1'b0, rr_ptr_reg} + (SRC_WD+1)'(gi);
            assign cand_idx[gi] = (rot_sum >= (SRC_WD+1)'(NUM_SRC))
                                ? SRC_WD'(rot_sum - (SRC_WD+1)'(NUM_SRC))
                                : rot_sum[SRC_WD-1:0];

            assign bus.s_ready_in[gi]  = (state_reg == ST_PAYLOAD) &&
                                         (grant_id_reg == SRC_WD'(gi)) && bus.ready_in;
            assign bus.s_ready_hdr[gi] = (state_reg == ST_HDR) &&
                                         (grant_id_reg == SRC_WD'(gi)) && bus.ready_insert;
        end
    endgenerate

    // Walk from the farthest candidate back to rr_ptr so the nearest eligible one wins.
    always_comb begin
        pick_valid_next = 1'b0;
        pick_idx_next   = '0;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            if (eligible[cand_idx[k]]) begin
                pick_valid_next = 1'b1;
                pick_idx_next   = cand_idx[k];
            end
        end
    end

    assign rr_ptr_next = (grant_id_reg == SRC_WD'(NUM_SRC - 1)) ? '0 : grant_id_reg + 1'b1;

    assign g_valid_hdr = bus.s_valid_hdr[grant_id_reg];
    assign g_valid_in  = bus.s_valid_in[grant_id_reg];
    assign g_las_in    = bus.s_las_in[grant_id_reg];

    always_comb begin
        bus.valid_insert    = 1'b0;
        bus.data_insert     = '0;
        bus.keep_insert     = '0;
        bus.byte_insert_cnt = '0;
        bus.valid_in        = 1'b0;
        bus.data_in         = '0;
        bus.keep_in         = '0;
        bus.las_in          = 1'b0;
        case (state_reg)
            ST_HDR: begin
                bus.valid_insert    = g_valid_hdr;
                bus.data_insert     = src_data_hdr[grant_id_reg];
                bus.keep_insert     = src_keep_hdr[grant_id_reg];
                bus.byte_insert_cnt = src_cnt_hdr[grant_id_reg];
            end
            ST_PAYLOAD: begin
                bus.valid_in = g_valid_in;
                bus.data_in  = src_data_in[grant_id_reg];
                bus.keep_in  = src_keep_in[grant_id_reg];
                bus.las_in   = g_las_in;
            end
            default: ;
        endcase
    end

    assign bus.grant_id = grant_id_reg;
    assign bus.busy     = busy_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            grant_id_reg <= '0;
            rr_ptr_reg   <= '0;
            busy_reg     <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (pick_valid_next) begin
                        grant_id_reg <= pick_idx_next;
                        state_reg    <= ST_HDR;
                        busy_reg     <= 1'b1;
                    end
                end
                ST_HDR: begin
                    if (g_valid_hdr && bus.ready_insert) begin
                        state_reg <= ST_PAYLOAD;
                    end
                end
                ST_PAYLOAD: begin
                    // Served source drops to lowest priority for the next round.
                    if (g_valid_in && bus.ready_in && g_las_in) begin
                        state_reg  <= ST_IDLE;
                        busy_reg   <= 1'b0;
                        rr_ptr_reg <= rr_ptr_next;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_stream_hdr_arbiter.sv
// Directed bench for axi_stream_hdr_arbiter (NUM_SRC=4, DATA_WD=32): per-cycle vector table
// plus hand-written sequences for back-pressure and header-stall corners.
module tb_axi_stream_hdr_arbiter;

    localparam int NUM_SRC = 4;
    localparam int DATA_WD = 32;
    localparam int S_I = 0;
    localparam int S_H = 1;
    localparam int S_P = 2;

    logic clk;
    logic rst_n;

    axi_stream_hdr_arbiter_if #(.NUM_SRC(NUM_SRC), .DATA_WD(DATA_WD)) bus ();

    axi_stream_hdr_arbiter #(.NUM_SRC(NUM_SRC), .DATA_WD(DATA_WD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n;
        logic [3:0] vin;
        logic [3:0] vh;
        logic [3:0] las;
        logic [3:0] e_rdy_in;
        logic [3:0] e_rdy_hdr;
        logic       e_vins;
        logic       e_vin;
        logic       e_las;
        logic [1:0] e_gid;
        logic       e_busy;
        logic       e_zero;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic logic [31:0] pay_data(int i);
        return 32'hD000_0000 + 32'(i);
    endfunction
    function automatic logic [31:0] hdr_data(int i);
        return (i == 2) ? 32'hA5A5_A5A5 : 32'h4800_0000 + 32'(i);
    endfunction
    function automatic logic [3:0] pay_keep(int i);
        return 4'(i + 1);
    endfunction
    function automatic logic [3:0] hdr_keep(int i);
        return 4'hF ^ 4'(i);
    endfunction
    function automatic logic [2:0] hdr_cnt(int i);
        return 3'(i + 1);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_sources(input logic [3:0] vin, input logic [3:0] vh, input logic [3:0] las);
        for (int i = 0; i < NUM_SRC; i++) begin
            bus.s_data_in[i*32 +: 32]    = pay_data(i);
            bus.s_keep_in[i*4 +: 4]      = pay_keep(i);
            bus.s_data_hdr[i*32 +: 32]   = hdr_data(i);
            bus.s_keep_hdr[i*4 +: 4]     = hdr_keep(i);
            bus.s_byte_hdr_cnt[i*3 +: 3] = hdr_cnt(i);
        end
        bus.s_valid_in  = vin;
        bus.s_valid_hdr = vh;
        bus.s_las_in    = las;
    endtask

    // Expected outputs follow from the hand-assigned state (st) and granted source (g) of each row.
    task automatic row(input logic rst, input logic [3:0] vin, input logic [3:0] vh,
                       input logic [3:0] las, input int st, input int g, input logic zero);
        vec_t v;
        v.rst_n     = rst;
        v.vin       = vin;
        v.vh        = vh;
        v.las       = las;
        v.e_rdy_hdr = (st == S_H) ? 4'(1 << g) : 4'b0;
        v.e_rdy_in  = (st == S_P) ? 4'(1 << g) : 4'b0;
        v.e_vins    = (st == S_H) ? vh[g] : 1'b0;
        v.e_vin     = (st == S_P) ? vin[g] : 1'b0;
        v.e_las     = (st == S_P) ? las[g] : 1'b0;
        v.e_gid     = 2'(g);
        v.e_busy    = (st != S_I);
        v.e_zero    = zero;
        vecs.push_back(v);
    endtask

    initial begin
        int beats;
        logic [31:0] got_data [4];
        logic        got_las  [4];

        rst_n = 1'b0;
        bus.ready_in     = 1'b0;
        bus.ready_insert = 1'b0;
        set_sources(4'b0, 4'b0, 4'b0);
        repeat (2) @(posedge clk);

        // Reset state and single requester (src2, 2-beat packet), then rr_ptr=3 check
        row(0, 4'b0000, 4'b0000, 4'b0000, S_I, 0, 1);
        row(1, 4'b0000, 4'b0000, 4'b0000, S_I, 0, 1);
        row(1, 4'b0100, 4'b0100, 4'b0000, S_I, 0, 0);
        row(1, 4'b0100, 4'b0100, 4'b0000, S_H, 2, 0);
        row(1, 4'b0100, 4'b0100, 4'b0000, S_P, 2, 0);
        row(1, 4'b0100, 4'b0100, 4'b0100, S_P, 2, 0);
        row(1, 4'b0000, 4'b0000, 4'b0000, S_I, 2, 0);
        row(1, 4'b1100, 4'b1100, 4'b1100, S_I, 2, 0);
        row(1, 4'b1100, 4'b1100, 4'b1100, S_H, 3, 0);
        row(1, 4'b1100, 4'b1100, 4'b1100, S_P, 3, 0);
        row(1, 4'b0000, 4'b0000, 4'b0000, S_I, 3, 0);
        // All sources eligible, 1-beat packets: grants 0,1,2,3,0 at 3 cycles each
        row(1, 4'b1111, 4'b1111, 4'b1111, S_I, 3, 0);
        for (int k = 0; k < 5; k++) begin
            row(1, 4'b1111, 4'b1111, 4'b1111, S_H, k % 4, 0);
            row(1, 4'b1111, 4'b1111, 4'b1111, S_P, k % 4, 0);
            if (k < 4) row(1, 4'b1111, 4'b1111, 4'b1111, S_I, k % 4, 0);
        end
        row(1, 4'b0000, 4'b0000, 4'b0000, S_I, 0, 0);
        // src0 lacks header valid: src3 wins twice, src0 only after its header is valid
        row(1, 4'b1001, 4'b1000, 4'b1000, S_I, 0, 0);
        row(1, 4'b1001, 4'b1000, 4'b1000, S_H, 3, 0);
        row(1, 4'b1001, 4'b1000, 4'b1000, S_P, 3, 0);
        row(1, 4'b1001, 4'b1000, 4'b1000, S_I, 3, 0);
        row(1, 4'b1001, 4'b1000, 4'b1000, S_H, 3, 0);
        row(1, 4'b1001, 4'b1000, 4'b1000, S_P, 3, 0);
        row(1, 4'b1001, 4'b1001, 4'b1001, S_I, 3, 0);
        row(1, 4'b1001, 4'b1001, 4'b1001, S_H, 0, 0);
        row(1, 4'b1001, 4'b1001, 4'b1001, S_P, 0, 0);
        row(1, 4'b0000, 4'b0000, 4'b0000, S_I, 0, 0);
        // Reset mid-payload of src2: outputs clear, rr_ptr back to 0 so src0 wins
        row(1, 4'b0100, 4'b0100, 4'b0000, S_I, 0, 0);
        row(1, 4'b0100, 4'b0100, 4'b0000, S_H, 2, 0);
        row(1, 4'b0100, 4'b0100, 4'b0000, S_P, 2, 0);
        row(0, 4'b0100, 4'b0100, 4'b0000, S_P, 2, 0);
        row(1, 4'b0101, 4'b0101, 4'b0001, S_I, 0, 1);
        row(1, 4'b0101, 4'b0101, 4'b0001, S_H, 0, 0);
        row(1, 4'b0101, 4'b0101, 4'b0001, S_P, 0, 0);
        row(1, 4'b0000, 4'b0000, 4'b0000, S_I, 0, 0);

        for (int r = 0; r < vecs.size(); r++) begin
            vec_t v;
            int   g;
            v = vecs[r];
            g = int'(v.e_gid);
            @(negedge clk);
            rst_n            = v.rst_n;
            bus.ready_in     = 1'b1;
            bus.ready_insert = 1'b1;
            set_sources(v.vin, v.vh, v.las);
            #1;
            check($sformatf("r%0d s_ready_in", r),   32'(bus.s_ready_in),   32'(v.e_rdy_in));
            check($sformatf("r%0d s_ready_hdr", r),  32'(bus.s_ready_hdr),  32'(v.e_rdy_hdr));
            check($sformatf("r%0d valid_insert", r), 32'(bus.valid_insert), 32'(v.e_vins));
            check($sformatf("r%0d valid_in", r),     32'(bus.valid_in),     32'(v.e_vin));
            check($sformatf("r%0d grant_id", r),     32'(bus.grant_id),     32'(v.e_gid));
            check($sformatf("r%0d busy", r),         32'(bus.busy),         32'(v.e_busy));
            if (v.e_vins) begin
                check($sformatf("r%0d data_insert", r), bus.data_insert, hdr_data(g));
                check($sformatf("r%0d keep_insert", r), 32'(bus.keep_insert), 32'(hdr_keep(g)));
                check($sformatf("r%0d byte_cnt", r),    32'(bus.byte_insert_cnt), 32'(hdr_cnt(g)));
            end
            if (v.e_vin) begin
                check($sformatf("r%0d data_in", r), bus.data_in, pay_data(g));
                check($sformatf("r%0d keep_in", r), 32'(bus.keep_in), 32'(pay_keep(g)));
                check($sformatf("r%0d las_in", r),  32'(bus.las_in), 32'(v.e_las));
            end
            if (v.e_zero) begin
                check($sformatf("r%0d zero data_in", r),     bus.data_in, 32'h0);
                check($sformatf("r%0d zero keep_in", r),     32'(bus.keep_in), 32'h0);
                check($sformatf("r%0d zero las_in", r),      32'(bus.las_in), 32'h0);
                check($sformatf("r%0d zero data_insert", r), bus.data_insert, 32'h0);
                check($sformatf("r%0d zero keep_insert", r), 32'(bus.keep_insert), 32'h0);
                check($sformatf("r%0d zero byte_cnt", r),    32'(bus.byte_insert_cnt), 32'h0);
            end
        end

        // src1 4-beat packet with ready_in toggling; other sources valid but header-less
        beats = 0;
        for (int c = 0; c < 40 && beats < 4; c++) begin
            @(negedge clk);
            set_sources(4'b1111, 4'b0010, (beats == 3) ? 4'b0010 : 4'b0000);
            bus.s_data_in[32 +: 32] = 32'hB000_0000 + 32'(beats);
            bus.ready_in     = ~c[0];
            bus.ready_insert = 1'b1;
            #1;
            check($sformatf("t3 c%0d foreign s_ready_in", c),  32'(bus.s_ready_in & 4'b1101), 32'h0);
            check($sformatf("t3 c%0d foreign s_ready_hdr", c), 32'(bus.s_ready_hdr & 4'b1101), 32'h0);
            if (bus.valid_in && bus.ready_in) begin
                got_data[beats] = bus.data_in;
                got_las[beats]  = bus.las_in;
                check($sformatf("t3 beat%0d grant_id", beats), 32'(bus.grant_id), 32'd1);
                check($sformatf("t3 beat%0d s_ready_in", beats), 32'(bus.s_ready_in), 32'b0010);
                beats++;
            end
        end
        check("t3 beat count", 32'(beats), 32'd4);
        for (int b = 0; b < beats && b < 4; b++) begin
            check($sformatf("t3 beat%0d data", b), got_data[b], 32'hB000_0000 + 32'(b));
            check($sformatf("t3 beat%0d las", b),  32'(got_las[b]), 32'(b == 3));
        end
        @(negedge clk);
        set_sources(4'b0000, 4'b0000, 4'b0000);
        #1;
        check("t3 idle busy", 32'(bus.busy), 32'd0);

        // Header stalled by ready_insert=0 for 5 cycles (src2)
        @(negedge clk);
        set_sources(4'b0100, 4'b0100, 4'b0100);
        bus.ready_in     = 1'b1;
        bus.ready_insert = 1'b0;
        #1;
        check("t6 idle valid_insert", 32'(bus.valid_insert), 32'd0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            #1;
            check($sformatf("t6 c%0d valid_insert", c), 32'(bus.valid_insert), 32'd1);
            check($sformatf("t6 c%0d data_insert", c),  bus.data_insert, 32'hA5A5_A5A5);
            check($sformatf("t6 c%0d byte_cnt", c),     32'(bus.byte_insert_cnt), 32'd3);
            check($sformatf("t6 c%0d s_ready_hdr", c),  32'(bus.s_ready_hdr), 32'd0);
            check($sformatf("t6 c%0d s_ready_in", c),   32'(bus.s_ready_in), 32'd0);
            check($sformatf("t6 c%0d valid_in", c),     32'(bus.valid_in), 32'd0);
        end
        @(negedge clk);
        bus.ready_insert = 1'b1;
        #1;
        check("t6 accept s_ready_hdr", 32'(bus.s_ready_hdr), 32'b0100);
        check("t6 accept grant_id",    32'(bus.grant_id), 32'd2);
        @(negedge clk);
        #1;
        check("t6 payload valid_in",   32'(bus.valid_in), 32'd1);
        check("t6 payload las_in",     32'(bus.las_in), 32'd1);
        check("t6 payload s_ready_in", 32'(bus.s_ready_in), 32'b0100);
        @(negedge clk);
        set_sources(4'b0000, 4'b0000, 4'b0000);
        #1;
        check("t6 end busy",     32'(bus.busy), 32'd0);
        check("t6 end grant_id", 32'(bus.grant_id), 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
